// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes and FSM state encoding.
// Imported by dmem_lsu and its lane-alignment helper.
package dmem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACCESS   = 2'd1,
        S_MERGE_WR = 2'd2,
        S_RESP     = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/dmem_lsu_align.sv
// Lane alignment for sub-word accesses: load extract/extend and store merge.
// Purely combinational; size and signedness come from funct3.
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [15:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        case (lane)
            2'd0:    lane_byte = word[7:0];
            2'd1:    lane_byte = word[15:8];
            2'd2:    lane_byte = word[23:16];
            default: lane_byte = word[31:24];
        endcase
        lane_half = lane[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    rdata = {{24{lane_byte[7]}}, lane_byte};
            F3_BU:   rdata = {24'd0, lane_byte};
            F3_H:    rdata = {{16{lane_half[15]}}, lane_half};
            F3_HU:   rdata = {16'd0, lane_half};
            default: rdata = word;
        endcase
    end

    // Only SB/SH reach the merge path; a full word never needs merging.
    always_comb begin
        merged = word;
        if (funct3[1:0] == 2'b00) begin
            case (lane)
                2'd0:    merged[7:0]   = wdata[7:0];
                2'd1:    merged[15:8]  = wdata[7:0];
                2'd2:    merged[23:16] = wdata[7:0];
                default: merged[31:24] = wdata[7:0];
            endcase
        end else if (funct3[1:0] == 2'b01) begin
            if (lane[1]) merged[31:16] = wdata;
            else         merged[15:0]  = wdata;
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit bridging RV32I byte/half/word accesses onto a word-only data memory.
// Sub-word stores use a read-modify-write; faulting requests never touch memory.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int WADDR_BITS = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [2:0]            req_funct3,
    input  logic [XLEN-1:0]       req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  rsp_valid,
    output logic [XLEN-1:0]       rsp_rdata,
    output logic                  rsp_err,
    output logic [WADDR_BITS-1:0] dataMemAddr,
    output logic [XLEN-1:0]       dataMemDataP2M,
    output logic                  dataMemWen,
    input  logic [XLEN-1:0]       dataMemDataM2P
);

    generate
        if (XLEN != 32) begin : g_xlen_check
            $error("dmem_lsu supports XLEN = 32 only");
        end
    endgenerate

    lsu_state_e            state;
    logic                  wen_q;
    logic [2:0]            f3_q;
    logic [1:0]            lane_q;
    logic [WADDR_BITS-1:0] idx_q;
    logic [XLEN-1:0]       wdata_q;
    logic [XLEN-1:0]       merge_q;
    logic [XLEN-1:0]       rdata_q;
    logic                  err_q;

    logic        accept;
    logic        misaligned;
    logic        out_of_range;
    logic        illegal;
    logic        req_err;
    logic        sw_phase;
    logic [31:0] ld_data;
    logic [31:0] st_merged;

    assign accept = req_valid && req_ready;

    always_comb begin
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                    || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = |req_addr[XLEN-1:WADDR_BITS+2];
        if (req_wen) illegal = (req_funct3 > F3_W);
        else         illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        req_err      = misaligned || out_of_range || illegal;
    end

    dmem_lsu_align u_align (
        .word   (dataMemDataM2P),
        .lane   (lane_q),
        .funct3 (f3_q),
        .wdata  (wdata_q[15:0]),
        .rdata  (ld_data),
        .merged (st_merged)
    );

    // rdata_q/err_q change only on the edge into RESP so they hold between responses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            wen_q   <= 1'b0;
            f3_q    <= 3'd0;
            lane_q  <= 2'd0;
            idx_q   <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        wen_q   <= req_wen;
                        f3_q    <= req_funct3;
                        lane_q  <= req_addr[1:0];
                        idx_q   <= req_addr[WADDR_BITS+1:2];
                        wdata_q <= req_wdata;
                        if (req_err) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            state   <= S_RESP;
                        end else begin
                            state   <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!wen_q) begin
                        rdata_q <= ld_data;
                        err_q   <= 1'b0;
                        state   <= S_RESP;
                    end else if (f3_q == F3_W) begin
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        state   <= S_RESP;
                    end else begin
                        merge_q <= st_merged;
                        state   <= S_MERGE_WR;
                    end
                end
                S_MERGE_WR: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    state   <= S_RESP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign sw_phase  = (state == S_ACCESS) && wen_q && (f3_q == F3_W);
    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign dataMemAddr = idx_q;

    // Gating by reset drops an in-flight merge write instead of half-completing it.
    assign dataMemWen = !reset && (sw_phase || (state == S_MERGE_WR));

    always_comb begin
        if (sw_phase)                  dataMemDataP2M = wdata_q;
        else if (state == S_MERGE_WR)  dataMemDataP2M = merge_q;
        else                           dataMemDataP2M = '0;
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed literal cases plus randomized traffic checked
// against a byte-level memory model and per-request latency/write-count rules.
module tb_dmem_lsu;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [4:0]  dataMemAddr;
    logic [31:0] dataMemDataP2M;
    logic        dataMemWen;
    logic [31:0] dataMemDataM2P;

    logic [31:0] mem [0:31];
    logic [31:0] model_mem [0:31];
    logic        bd_en;
    logic [4:0]  bd_idx;
    logic [31:0] bd_data;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    dmem_lsu #(.XLEN(32), .WADDR_BITS(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wen        (req_wen),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .dataMemAddr    (dataMemAddr),
        .dataMemDataP2M (dataMemDataP2M),
        .dataMemWen     (dataMemWen),
        .dataMemDataM2P (dataMemDataM2P)
    );

    assign dataMemDataM2P = mem[dataMemAddr];

    always @(posedge clock) begin
        if (dataMemWen) mem[dataMemAddr] <= dataMemDataP2M;
        if (bd_en)      mem[bd_idx] <= bd_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] data);
        @(negedge clock);
        bd_en = 1'b1; bd_idx = idx[4:0]; bd_data = data;
        @(posedge clock);
        #1 bd_en = 1'b0;
        model_mem[idx] = data;
    endtask

    // Reference: byte-addressed rules applied to a plain word array.
    task automatic model_step(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rd,
                              output logic er, output int lat, output int nwr);
        int idx, lane, bytes;
        logic [31:0] v, mask;
        idx  = int'(addr % 128) / 4;
        lane = int'(addr % 4);
        case (f3 % 4)
            0: bytes = 1;
            1: bytes = 2;
            2: bytes = 4;
            default: bytes = 0;
        endcase
        er = 1'b0;
        if (wen && f3 > 2) er = 1'b1;
        if (!wen && (f3 == 3 || f3 == 6 || f3 == 7)) er = 1'b1;
        if (addr >= 128) er = 1'b1;
        if (bytes > 1 && (addr % bytes) != 0) er = 1'b1;
        rd = 32'd0; nwr = 0;
        if (er) begin
            lat = 1;
        end else if (!wen) begin
            lat = 2;
            v = model_mem[idx] >> (8 * lane);
            if (bytes == 1) begin
                rd = v & 32'hFF;
                if (f3 < 4 && rd >= 32'h80) rd = rd + 32'hFFFFFF00;
            end else if (bytes == 2) begin
                rd = v & 32'hFFFF;
                if (f3 < 4 && rd >= 32'h8000) rd = rd + 32'hFFFF0000;
            end else begin
                rd = model_mem[idx];
            end
        end else begin
            nwr = 1;
            lat = (bytes == 4) ? 2 : 3;
            if (bytes == 4) mask = 32'hFFFFFFFF;
            else            mask = ((bytes == 1) ? 32'hFF : 32'hFFFF) << (8 * lane);
            model_mem[idx] = (model_mem[idx] & ~mask) | ((wdata << (8 * lane)) & mask);
        end
    endtask

    task automatic do_req(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                          output logic er, output int nwr, output logic busy_bad);
        @(negedge clock);
        check("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = -1; nwr = 0; rd = 32'hx; er = 1'bx; busy_bad = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (dataMemWen) nwr++;
            if (rsp_valid) begin
                lat = c; rd = rsp_rdata; er = rsp_err;
                break;
            end
            if (req_ready) busy_bad = 1'b1;
        end
    endtask

    task automatic run_txn(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rd, output logic er);
        logic [31:0] e_rd;
        logic        e_er, busy_bad;
        int          e_lat, e_nwr, lat, nwr, idx;
        model_step(wen, f3, addr, wdata, e_rd, e_er, e_lat, e_nwr);
        do_req(wen, f3, addr, wdata, lat, rd, er, nwr, busy_bad);
        idx = int'(addr % 128) / 4;
        check("latency", lat, e_lat);
        check("rsp_rdata", rd, e_rd);
        check("rsp_err", {31'd0, er}, {31'd0, e_er});
        check("write_count", nwr, e_nwr);
        check("ready_busy", {31'd0, busy_bad}, 32'd0);
        check("mem_word", mem[idx], model_mem[idx]);
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        logic        w;
        logic [2:0]  f;
        logic [31:0] a, d;
        int          sel;

        reset = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; bd_en = 1'b0; bd_idx = 5'd0; bd_data = 32'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        check("rst_addr", {27'd0, dataMemAddr}, 32'd0);
        check("rst_wen", {31'd0, dataMemWen}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) poke(i, $urandom);

        // Directed cases with hand-computed results
        poke(3, 32'h8899AABB);
        run_txn(1'b0, 3'b000, 32'h0E, 32'd0, rd, er);
        check("lb_0e", rd, 32'hFFFFFF99);
        run_txn(1'b0, 3'b101, 32'h0C, 32'd0, rd, er);
        check("lhu_0c", rd, 32'h0000AABB);
        run_txn(1'b0, 3'b001, 32'h0E, 32'd0, rd, er);
        check("lh_0e", rd, 32'hFFFF8899);
        poke(5, 32'h11223344);
        run_txn(1'b1, 3'b000, 32'h15, 32'h000000A5, rd, er);
        check("sb_15_mem", mem[5], 32'h1122A544);
        run_txn(1'b1, 3'b010, 32'h7C, 32'hDEADBEEF, rd, er);
        check("sw_7c_mem", mem[31], 32'hDEADBEEF);
        run_txn(1'b0, 3'b010, 32'h7C, 32'd0, rd, er);
        check("lw_7c", rd, 32'hDEADBEEF);
        run_txn(1'b0, 3'b010, 32'h02, 32'd0, rd, er);
        check("err_lw_02", {31'd0, er}, 32'd1);
        run_txn(1'b1, 3'b001, 32'h01, 32'h1234, rd, er);
        check("err_sh_01", {31'd0, er}, 32'd1);
        run_txn(1'b0, 3'b010, 32'h80, 32'd0, rd, er);
        check("err_lw_80", {31'd0, er}, 32'd1);
        run_txn(1'b0, 3'b011, 32'h00, 32'd0, rd, er);
        check("err_f3_011", {31'd0, er}, 32'd1);

        // Reset landing in the merge-write cycle must drop the write
        poke(2, 32'h01020304);
        @(negedge clock);
        req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h08; req_wdata = 32'h0000BEEF;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        check("rmw_access_nowr", {31'd0, dataMemWen}, 32'd0);
        @(negedge clock);
        check("rmw_merge_wen", {31'd0, dataMemWen}, 32'd1);
        reset = 1'b1;
        #1 check("rmw_reset_gate", {31'd0, dataMemWen}, 32'd0);
        @(negedge clock);
        check("rmw_ready", {31'd0, req_ready}, 32'd1);
        check("rmw_no_rsp", {31'd0, rsp_valid}, 32'd0);
        check("rmw_mem_kept", mem[2], 32'h01020304);
        check("rmw_addr_rst", {27'd0, dataMemAddr}, 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("rmw_quiet", {31'd0, rsp_valid}, 32'd0);
        end

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            w   = 1'($urandom_range(0, 1));
            f   = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = $urandom;
            else if (sel == 1) a = $urandom_range(128, 200);
            else               a = $urandom_range(0, 127);
            if ($urandom_range(0, 1) == 1) a = a & 32'hFFFFFFFC;
            d = $urandom;
            run_txn(w, f, a, d, rd, er);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clock);
                check("hold_rdata", rsp_rdata, rd);
                check("hold_err", {31'd0, rsp_err}, {31'd0, er});
            end
        end

        @(negedge clock);
        for (int i = 0; i < 32; i++) check("final_mem", mem[i], model_mem[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
